// File: rtl/lsu_dbus_master.sv
// Load/store data-bus initiator: one access at a time, lane steering, load extension.
// Optional LSU_TIMEOUT_EN: WAIT-state timeout that ends the access with lsu_bus_err_o.
module lsu_dbus_master #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            lsu_ld_i,
   input  logic            lsu_st_i,
   input  logic [1:0]      lsu_size_i,
   input  logic            lsu_unsigned_i,
   input  logic [XLEN-1:0] lsu_addr_i,
   input  logic [XLEN-1:0] lsu_wdata_i,
   output logic            lsu_busy_o,
   output logic            lsu_done_o,
   output logic [XLEN-1:0] lsu_rdata_o,
   output logic            lsu_misalign_o,
   output logic            lsu_bus_err_o,
   output logic            dbus_req_o,
   output logic            dbus_w_en_o,
   output logic [XLEN-1:0] dbus_addr_o,
   output logic [XLEN-1:0] dbus_w_data_o,
   output logic [3:0]      dbus_sel_byte_o,
   input  logic [XLEN-1:0] dbus_r_data_i,
   input  logic            dbus_ack_i
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   state_e          state_q, state_d;
   logic            w_en_q, w_en_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [3:0]      sel_q, sel_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            misalign_q, misalign_d;
   logic            bus_err_q, bus_err_d;

   logic [3:0]      sel_in;
   logic [XLEN-1:0] wdata_in;
   logic            misalign_in;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_ext;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;
   assign cnt_d   = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   wire unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

   // Lane steering and alignment check for the request presented in IDLE.
   always_comb begin
      sel_in      = 4'b1111;
      wdata_in    = lsu_wdata_i;
      misalign_in = |lsu_addr_i[1:0];
      case (lsu_size_i)
         2'b00: begin
            sel_in      = 4'b0001 << lsu_addr_i[1:0];
            wdata_in    = {4{lsu_wdata_i[7:0]}};
            misalign_in = 1'b0;
         end
         2'b01: begin
            sel_in      = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_in    = {2{lsu_wdata_i[15:0]}};
            misalign_in = lsu_addr_i[0];
         end
         default: ;
      endcase
   end

   assign ld_byte = dbus_r_data_i[{addr_q[1:0], 3'b000} +: 8];
   assign ld_half = dbus_r_data_i[{addr_q[1], 4'b0000} +: 16];

   always_comb begin
      case (size_q)
         2'b00:   ld_ext = {{(XLEN-8){~uns_q & ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = {{(XLEN-16){~uns_q & ld_half[15]}}, ld_half};
         default: ld_ext = dbus_r_data_i;
      endcase
   end

   always_comb begin
      // NOTE: every next-state value defaults to its register so no path infers a latch.
      state_d    = state_q;
      w_en_d     = w_en_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      sel_d      = sel_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = misalign_q;
      bus_err_d  = bus_err_q;
      case (state_q)
         S_IDLE: begin
            if (lsu_st_i || lsu_ld_i) begin
               w_en_d     = lsu_st_i;
               size_d     = lsu_size_i;
               uns_d      = lsu_unsigned_i;
               addr_d     = lsu_addr_i;
               sel_d      = sel_in;
               wdata_d    = wdata_in;
               rdata_d    = '0;
               misalign_d = misalign_in;
               bus_err_d  = 1'b0;
               state_d    = misalign_in ? S_DONE : S_REQ;
            end
         end
         S_REQ, S_WAIT: begin
            if (state_q == S_REQ) state_d = S_WAIT;
            if (dbus_ack_i) begin
               rdata_d = w_en_q ? '0 : ld_ext;
               state_d = S_DONE;
            end
`ifdef LSU_TIMEOUT_EN
            else if (state_q == S_WAIT && timeout) begin
               rdata_d   = '0;
               bus_err_d = 1'b1;
               state_d   = S_DONE;
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         w_en_q     <= 1'b0;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         sel_q      <= 4'b0000;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         w_en_q     <= w_en_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         addr_q     <= addr_d;
         sel_q      <= sel_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

`ifdef LSU_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`endif

   assign lsu_busy_o      = (state_q != S_IDLE);
   assign lsu_done_o      = (state_q == S_DONE);
   assign lsu_rdata_o     = lsu_done_o ? rdata_q : '0;
   assign lsu_misalign_o  = lsu_done_o & misalign_q;
   assign lsu_bus_err_o   = lsu_done_o & bus_err_q;
   assign dbus_req_o      = (state_q == S_REQ);
   assign dbus_w_en_o     = w_en_q;
   assign dbus_addr_o     = {addr_q[XLEN-1:2], 2'b00};
   assign dbus_w_data_o   = wdata_q;
   assign dbus_sel_byte_o = sel_q;

endmodule
